// File: rtl/mem_bus_ctrl.sv
// Memory/bus controller behind the multicycle CPU memory port: decodes RAM / IO / unmapped,
// sequences a wait-stated synchronous RAM or an IO register access, and returns data + ready.
module mem_bus_ctrl #(
  parameter int          RAM_AW  = 12,
  parameter int          RAM_LAT = 1,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic [31:0]       iAddr,
  input  logic [31:0]       iWData,
  input  logic              iRead,
  input  logic              iWrite,
  output logic [31:0]       oRData,
  output logic              oRDY,
  output logic [RAM_AW-1:0] oRamAddr,
  output logic [31:0]       oRamWData,
  output logic              oRamWE,
  output logic              oRamRE,
  input  logic [31:0]       iRamRData,
  input  logic [15:0]       iSW,
  output logic [15:0]       oLED,
  output logic              oBusErr
);

  typedef enum logic [2:0] {S_IDLE, S_RAM_ISSUE, S_RAM_WAIT, S_IO_ACC, S_DONE} state_t;

  localparam logic [32:0] RAM_TOP = 33'd4 << RAM_AW;

  state_t      state_q, state_d;
  logic        req, is_ram, is_io;
  logic        rw_q;
  logic [1:0]  io_off_q;
  logic [15:0] io_wdata_q;
  logic [2:0]  cnt_q;
  logic [31:0] timer_q;
  logic [15:0] sw_meta, sw_sync;
  logic        io_wr, io_rd, ram_last;

  assign req      = iRead | iWrite;
  assign is_ram   = {1'b0, iAddr} < RAM_TOP;
  assign is_io    = iAddr[31:4] == IO_BASE[31:4];
  assign io_wr    = (state_q == S_IO_ACC) &&  rw_q;
  assign io_rd    = (state_q == S_IO_ACC) && !rw_q;
  assign ram_last = (state_q == S_RAM_WAIT) && (cnt_q == 3'd1);

  always_comb begin
    state_d = state_q;
    oRDY    = 1'b0;
    oRamWE  = 1'b0;
    oRamRE  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // idle steps must not stall the CPU step counter
        oRDY = ~req;
        if (req) begin
          if (is_ram)     state_d = S_RAM_ISSUE;
          else if (is_io) state_d = S_IO_ACC;
          else            state_d = S_DONE;
        end
      end
      S_RAM_ISSUE: begin
        oRamWE  = rw_q;
        oRamRE  = ~rw_q;
        state_d = S_RAM_WAIT;
      end
      S_RAM_WAIT: if (cnt_q == 3'd1) state_d = S_DONE;
      S_IO_ACC:   state_d = S_DONE;
      S_DONE: begin
        oRDY    = 1'b1;
        state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      io_off_q   <= 2'd0;
      io_wdata_q <= 16'd0;
      cnt_q      <= 3'd0;
      oRamAddr   <= '0;
      oRamWData  <= 32'd0;
      oRData     <= 32'd0;
      oLED       <= 16'd0;
      oBusErr    <= 1'b0;
      timer_q    <= 32'd0;
      sw_meta    <= 16'd0;
      sw_sync    <= 16'd0;
    end else begin
      state_q <= state_d;
      sw_meta <= iSW;
      sw_sync <= sw_meta;
      // a timer write-clear wins over the free-running increment
      if (io_wr && io_off_q == 2'd2) timer_q <= 32'd0;
      else                           timer_q <= timer_q + 32'd1;

      if (state_q == S_IDLE && req) begin
        rw_q       <= iWrite;
        io_off_q   <= iAddr[3:2];
        io_wdata_q <= iWData[15:0];
        if (is_ram) begin
          oRamAddr  <= iAddr[RAM_AW+1:2];
          oRamWData <= iWData;
        end else if (!is_io) begin
          oBusErr <= 1'b1;
          if (!iWrite) oRData <= 32'd0;
        end
      end

      if (state_q == S_RAM_ISSUE) cnt_q <= 3'(RAM_LAT);
      else if (state_q == S_RAM_WAIT) cnt_q <= cnt_q - 3'd1;

      if (ram_last && !rw_q) oRData <= iRamRData;

      if (io_wr && io_off_q == 2'd0) oLED <= io_wdata_q;
      if (io_rd) begin
        case (io_off_q)
          2'd0:    oRData <= {16'd0, oLED};
          2'd1:    oRData <= {16'd0, sw_sync};
          2'd2:    oRData <= timer_q;
          default: oRData <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table of single accesses plus timer, dual-request
// and mid-transaction reset sequences; RAM modelled with RAM_LAT=1.
module tb_mem_bus_ctrl;
  localparam int RAM_AW = 12;

  logic              iClk = 1'b0;
  logic              nRst = 1'b0;
  logic [31:0]       iAddr = '0, iWData = '0;
  logic              iRead = 1'b0, iWrite = 1'b0;
  logic [31:0]       oRData;
  logic              oRDY;
  logic [RAM_AW-1:0] oRamAddr;
  logic [31:0]       oRamWData;
  logic              oRamWE, oRamRE;
  logic [31:0]       iRamRData = '0;
  logic [15:0]       iSW = '0;
  logic [15:0]       oLED;
  logic              oBusErr;

  mem_bus_ctrl #(.RAM_AW(RAM_AW), .RAM_LAT(1), .IO_BASE(32'hFFFF_0000)) dut (
    .iClk(iClk), .nRst(nRst), .iAddr(iAddr), .iWData(iWData), .iRead(iRead), .iWrite(iWrite),
    .oRData(oRData), .oRDY(oRDY), .oRamAddr(oRamAddr), .oRamWData(oRamWData),
    .oRamWE(oRamWE), .oRamRE(oRamRE), .iRamRData(iRamRData), .iSW(iSW), .oLED(oLED),
    .oBusErr(oBusErr)
  );

  always #5 iClk = ~iClk;

  // synchronous RAM, one cycle read latency
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  always @(posedge iClk) begin
    if (oRamWE) mem[oRamAddr] <= oRamWData;
    if (oRamRE) iRamRData <= mem[oRamAddr];
  end

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge after the ready cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output int rcyc, output int rabs, output logic [31:0] rdat,
                           output int we_n, output int re_n, output logic [RAM_AW-1:0] raddr);
    iRead = rd; iWrite = wr; iAddr = a; iWData = wd;
    rcyc = -1; rabs = 0; rdat = 'x; we_n = 0; re_n = 0; raddr = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (oRamWE) begin we_n++; raddr = oRamAddr; end
      if (oRamRE) begin re_n++; raddr = oRamAddr; end
      if (oRDY) begin rcyc = c; rabs = cyc; rdat = oRData; break; end
      @(negedge iClk);
    end
    iRead = 1'b0; iWrite = 1'b0;
    @(negedge iClk);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int          exp_cyc;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic        exp_err;
    int          exp_we, exp_re;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int rc, ra, wn, rn, rc2, ra2;
    logic [31:0] rd;
    logic [RAM_AW-1:0] rad;
    logic [RAM_AW-1:0] exp_ra;
    int rdy_seen [2];
    int n_rdy;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 3, 1'b0, 32'h0,         16'h0000, 1'b0, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b1, 32'hCAFE_F00D, 16'h0000, 1'b0, 0, 1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         3, 1'b1, 32'hCAFE_F00D, 16'h0000, 1'b0, 0, 1};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_A5A5, 2, 1'b0, 32'h0,         16'hA5A5, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_0004, 32'h0,         2, 1'b1, 32'h0000_1234, 16'hA5A5, 1'b0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_0000, 32'h0,         2, 1'b1, 32'h0000_A5A5, 16'hA5A5, 1'b0, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_FFFF, 2, 1'b0, 32'h0,         16'hA5A5, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         2, 1'b1, 32'h0,         16'hA5A5, 1'b0, 0, 0};
    vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_000C, 32'h0000_1111, 2, 1'b0, 32'h0,         16'hA5A5, 1'b0, 0, 0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_3FFC, 32'h1234_5678, 3, 1'b0, 32'h0,         16'hA5A5, 1'b0, 1, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         3, 1'b1, 32'h1234_5678, 16'hA5A5, 1'b0, 0, 1};
    vecs[11] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1, 1'b1, 32'h0,         16'hA5A5, 1'b1, 0, 0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         3, 1'b1, 32'h1234_5678, 16'hA5A5, 1'b1, 0, 1};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFF_0010, 32'hDEAD_BEEF, 1, 1'b1, 32'h1234_5678, 16'hA5A5, 1'b1, 0, 0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         1, 1'b1, 32'h0,         16'hA5A5, 1'b1, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_5A5A, 2, 1'b0, 32'h0,         16'h5A5A, 1'b1, 0, 0};

    // reset state
    iSW = 16'h1234;
    repeat (2) @(negedge iClk);
    #1;
    chk("rst_rdy", 0, 32'(oRDY), 32'd1);
    chk("rst_rdata", 0, oRData, 32'd0);
    chk("rst_led", 0, 32'(oLED), 32'd0);
    chk("rst_err", 0, 32'(oBusErr), 32'd0);
    chk("rst_strobe", 0, 32'({oRamWE, oRamRE}), 32'd0);
    chk("rst_ramaddr", 0, 32'(oRamAddr), 32'd0);
    @(negedge iClk);
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk); #1;
      chk("idle_rdy", i, 32'(oRDY), 32'd1);
      chk("idle_strobe", i, 32'({oRamWE, oRamRE}), 32'd0);
    end
    @(negedge iClk);

    // single-access vector table
    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rc, ra, rd, wn, rn, rad);
      chk("lat", i, 32'(rc), 32'(vecs[i].exp_cyc));
      if (vecs[i].chk_rd) chk("rdata", i, rd, vecs[i].exp_rdata);
      chk("led", i, 32'(oLED), 32'(vecs[i].exp_led));
      chk("buserr", i, 32'(oBusErr), 32'(vecs[i].exp_err));
      chk("we_cnt", i, 32'(wn), 32'(vecs[i].exp_we));
      chk("re_cnt", i, 32'(rn), 32'(vecs[i].exp_re));
      if (vecs[i].exp_we + vecs[i].exp_re > 0) begin
        exp_ra = vecs[i].addr[RAM_AW+1:2];
        chk("ramaddr", i, 32'(rad), 32'(exp_ra));
      end
    end

    // timer: clear, idle, read back elapsed cycles
    do_access(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, rc, ra, rd, wn, rn, rad);
    chk("tmr_clr_lat", 0, 32'(rc), 32'd2);
    repeat (10) @(negedge iClk);
    do_access(1'b1, 1'b0, 32'hFFFF_0008, 32'h0, rc2, ra2, rd, wn, rn, rad);
    chk("tmr_rd_lat", 0, 32'(rc2), 32'd2);
    chk("tmr_val", 0, rd, 32'(ra2 - ra - 1));
    chk("tmr_val_abs", 0, rd, 32'd12);

    // read and write both high, held through DONE: write, then a second access
    iRead = 1'b1; iWrite = 1'b1; iAddr = 32'hFFFF_0000; iWData = 32'd7;
    n_rdy = 0; rdy_seen[0] = -1; rdy_seen[1] = -1;
    for (int c = 0; c < 20 && n_rdy < 2; c++) begin
      #1;
      if (oRDY) begin
        rdy_seen[n_rdy] = c;
        if (n_rdy == 0) chk("both_led", 0, 32'(oLED), 32'd7);
        n_rdy++;
      end
      if (n_rdy < 2) @(negedge iClk);
    end
    iRead = 1'b0; iWrite = 1'b0;
    chk("both_rdy1", 0, 32'(rdy_seen[0]), 32'd2);
    chk("both_rdy2", 0, 32'(rdy_seen[1]), 32'd5);
    @(negedge iClk);

    // reset asserted during RAM_WAIT aborts the read
    iRead = 1'b1; iAddr = 32'h0000_0010;
    @(negedge iClk); #1;
    chk("abort_issue_re", 0, 32'(oRamRE), 32'd1);
    @(negedge iClk); #1;
    chk("abort_wait_rdy", 0, 32'(oRDY), 32'd0);
    nRst = 1'b0;
    #1;
    chk("abort_strobe", 0, 32'({oRamWE, oRamRE}), 32'd0);
    chk("abort_rdy", 0, 32'(oRDY), 32'd0);
    chk("abort_err", 0, 32'(oBusErr), 32'd0);
    chk("abort_led", 0, 32'(oLED), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk); #1;
      chk("abort_hold_rdy", i, 32'(oRDY), 32'd0);
    end
    iRead = 1'b0;
    @(negedge iClk);
    nRst = 1'b1;
    @(negedge iClk); #1;
    chk("post_rst_rdy", 0, 32'(oRDY), 32'd1);
    chk("post_rst_rdata", 0, oRData, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
